avl_master_split: RTL and testbench

AVL_MASTER_SPLIT -- requirements
Module: avl_master_split

---
 rtl/avl_master_split.sv | 185 ++++++++++++++++++
 tb/tb_avl_master_split.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avl_master_split.sv
// Avalon-MM master that turns right-justified, possibly unaligned processor accesses into word beats.
// Define AVL_MASTER_SPLIT_EN to issue a second beat for lanes crossing the word boundary; otherwise those lanes are dropped and misalign_err pulses.

module avl_master_split #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W-1:0]   avl_readdata,
  input  logic                avl_waitrequest,
  output logic [ADDR_W-1:0]   avl_address,
  output logic [DATA_W/8-1:0] avl_byteenable,
  output logic [DATA_W-1:0]   avl_writedata,
  output logic                avl_read,
  output logic                avl_write,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W-1:0]   write_data,
  input  logic [DATA_W/8-1:0] byteenable,
  input  logic                read_select,
  input  logic                write_select,
  output logic [DATA_W-1:0]   read_data,
  output logic                busy,
  output logic                misalign_err
);

  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = $clog2(BE_W);

`ifdef AVL_MASTER_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;

  state_t                state_q, state_d;
  logic                  req_valid, lo_in, hi_in, accept, null_req;
  logic                  need_beat1, final_beat, read_done, op_read_q;
  logic [OFF_W-1:0]      off_in, off_q;
  logic [2*BE_W-1:0]     lanes_in, lanes_q;
  logic [2*DATA_W-1:0]   wdata_in, wdata_q, read_pair, read_shift;
  logic [ADDR_W-1:0]     base_in, base_q;
  logic [DATA_W-1:0]     lane_mask, beat_rd, beat0_q, read_data_q;

  assign req_valid  = !rst && (read_select ^ write_select) && (|byteenable);
  assign off_in     = address[OFF_W-1:0];
  assign lanes_in   = {{BE_W{1'b0}}, byteenable} << off_in;
  assign wdata_in   = {{DATA_W{1'b0}}, write_data} << {off_in, 3'b000};
  assign base_in    = {address[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign lo_in      = |lanes_in[BE_W-1:0];
  assign hi_in      = SPLIT_EN && (|lanes_in[2*BE_W-1:BE_W]);
  assign accept     = (state_q == IDLE) && req_valid && (lo_in || hi_in);
  // Without splitting, a request whose lanes all cross the boundary has nothing to issue.
  assign null_req   = (state_q == IDLE) && req_valid && !(lo_in || hi_in);
  assign need_beat1 = SPLIT_EN && (|lanes_q[2*BE_W-1:BE_W]);

`ifdef AVL_MASTER_SPLIT_EN
  assign misalign_err = 1'b0;
`else
  assign misalign_err = (state_q == IDLE) && req_valid && (|lanes_in[2*BE_W-1:BE_W]);
`endif

  always_comb begin
    lane_mask = '0;
    for (int i = 0; i < BE_W; i++) begin
      lane_mask[8*i +: 8] = {8{avl_byteenable[i]}};
    end
  end

  assign beat_rd    = avl_readdata & lane_mask;
  assign read_pair  = (state_q == BEAT1) ? {beat_rd, beat0_q} : {{DATA_W{1'b0}}, beat_rd};
  assign read_shift = read_pair >> {off_q, 3'b000};
  assign read_done  = final_beat && op_read_q;

  always_comb begin
    read_data = read_data_q;
    if (read_done) begin
      read_data = read_shift[DATA_W-1:0];
    end else if (null_req && read_select) begin
      read_data = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    busy       = 1'b0;
    final_beat = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          busy    = 1'b1;
          state_d = lo_in ? BEAT0 : BEAT1;
        end
      end
      BEAT0: begin
        if (avl_waitrequest) begin
          busy = 1'b1;
        end else if (need_beat1) begin
          busy    = 1'b1;
          state_d = BEAT1;
        end else begin
          final_beat = 1'b1;
          state_d    = IDLE;
        end
      end
      BEAT1: begin
        if (avl_waitrequest) begin
          busy = 1'b1;
        end else begin
          final_beat = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus outputs are loaded one cycle ahead of each beat and frozen while the slave stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      avl_address    <= '0;
      avl_byteenable <= '1;
      avl_writedata  <= '0;
      avl_read       <= 1'b0;
      avl_write      <= 1'b0;
      op_read_q      <= 1'b0;
      lanes_q        <= '0;
      wdata_q        <= '0;
      base_q         <= '0;
      off_q          <= '0;
      beat0_q        <= '0;
      read_data_q    <= '0;
    end else begin
      if (accept) begin
        op_read_q <= read_select;
        lanes_q   <= lanes_in;
        wdata_q   <= wdata_in;
        base_q    <= base_in;
        off_q     <= off_in;
        beat0_q   <= '0;
        avl_read  <= read_select;
        avl_write <= write_select;
        if (lo_in) begin
          avl_address    <= base_in;
          avl_byteenable <= lanes_in[BE_W-1:0];
          avl_writedata  <= wdata_in[DATA_W-1:0];
        end else begin
          avl_address    <= base_in + ADDR_W'(BE_W);
          avl_byteenable <= lanes_in[2*BE_W-1:BE_W];
          avl_writedata  <= wdata_in[2*DATA_W-1:DATA_W];
        end
      end else if (state_q == BEAT0 && !avl_waitrequest) begin
        beat0_q <= beat_rd;
        if (need_beat1) begin
          avl_address    <= base_q + ADDR_W'(BE_W);
          avl_byteenable <= lanes_q[2*BE_W-1:BE_W];
          avl_writedata  <= wdata_q[2*DATA_W-1:DATA_W];
        end else begin
          avl_read  <= 1'b0;
          avl_write <= 1'b0;
        end
      end else if (state_q == BEAT1 && !avl_waitrequest) begin
        avl_read  <= 1'b0;
        avl_write <= 1'b0;
      end

      if (read_done) begin
        read_data_q <= read_shift[DATA_W-1:0];
      end else if (null_req && read_select) begin
        read_data_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_avl_master_split.sv
// Self-checking bench for avl_master_split: directed cases plus random accesses against a byte-level memory model.
// Honours AVL_MASTER_SPLIT_EN the same way as the design.

module tb_avl_master_split;

`ifdef AVL_MASTER_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] avl_readdata;
  logic        avl_waitrequest;
  logic [31:0] avl_address;
  logic [3:0]  avl_byteenable;
  logic [31:0] avl_writedata;
  logic        avl_read;
  logic        avl_write;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [3:0]  byteenable;
  logic        read_select;
  logic        write_select;
  logic [31:0] read_data;
  logic        busy;
  logic        misalign_err;

  int checks = 0;
  int errors = 0;

  logic [7:0]  slave_mem [logic [31:0]];
  logic [7:0]  ref_mem [logic [31:0]];
  logic [31:0] beat_addr [$];
  logic [3:0]  beat_ben [$];
  logic [31:0] beat_data [$];
  bit          hold_pend = 1'b0;
  logic [69:0] hold_val;
  logic [31:0] last_read = 32'h0;

  always #5 clk = ~clk;

  avl_master_split #(.DATA_W(32), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .avl_readdata(avl_readdata), .avl_waitrequest(avl_waitrequest),
    .avl_address(avl_address), .avl_byteenable(avl_byteenable),
    .avl_writedata(avl_writedata), .avl_read(avl_read), .avl_write(avl_write),
    .address(address), .write_data(write_data), .byteenable(byteenable),
    .read_select(read_select), .write_select(write_select),
    .read_data(read_data), .busy(busy), .misalign_err(misalign_err)
  );

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] slaveWord(input logic [31:0] a);
    logic [31:0] w = 32'h0;
    for (int i = 0; i < 4; i++) begin
      logic [31:0] ba = 32'(a + i);
      w[8*i +: 8] = slave_mem.exists(ba) ? slave_mem[ba] : 8'h00;
    end
    return w;
  endfunction

  function automatic logic [7:0] refGet(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      slave_mem[32'(a + i)] = w[8*i +: 8];
      ref_mem[32'(a + i)]   = w[8*i +: 8];
    end
  endtask

  // Byte i of a request targets byte address addr+i; bytes landing past the word end are lost unless splitting.
  task automatic modelExpect(input logic [31:0] a, input logic [3:0] ben,
                             output logic [31:0] rd, output int nbeats, output bit mis);
    bit in_first = 1'b0, in_second = 1'b0;
    rd = 32'h0;
    for (int i = 0; i < 4; i++) begin
      if (ben[i]) begin
        if (int'(a[1:0]) + i < 4) begin
          in_first = 1'b1;
          rd[8*i +: 8] = refGet(32'(a + i));
        end else begin
          in_second = 1'b1;
          if (SPLIT) rd[8*i +: 8] = refGet(32'(a + i));
        end
      end
    end
    nbeats = int'(in_first) + (SPLIT ? int'(in_second) : 0);
    mis    = !SPLIT && in_second;
  endtask

  task automatic modelWrite(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ben);
    for (int i = 0; i < 4; i++) begin
      if (ben[i] && (SPLIT || int'(a[1:0]) + i < 4)) ref_mem[32'(a + i)] = wd[8*i +: 8];
    end
  endtask

  // Slave model: read data follows the address; beats and write commits are logged once waitrequest is settled.
  always @(posedge clk) begin
    #1;
    avl_readdata = slaveWord(avl_address);
  end

  always @(negedge clk) begin
    #2;
    if (rst) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        checkOutput("hold_stable", {avl_read, avl_write, avl_address, avl_byteenable, avl_writedata}, hold_val);
      end
      hold_pend = (avl_read || avl_write) && avl_waitrequest;
      hold_val  = {avl_read, avl_write, avl_address, avl_byteenable, avl_writedata};
      if ((avl_read || avl_write) && !avl_waitrequest) begin
        beat_addr.push_back(avl_address);
        beat_ben.push_back(avl_byteenable);
        beat_data.push_back(avl_writedata);
        if (avl_write) begin
          for (int i = 0; i < 4; i++) begin
            if (avl_byteenable[i]) slave_mem[32'(avl_address + i)] = avl_writedata[8*i +: 8];
          end
        end
      end
    end
  end

  // wmode: 0 = no stalls, 1 = random stalls, 2 = first three beat cycles stalled.
  task automatic applyStimulus(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                               input logic [3:0] ben, input int wmode,
                               output int lat, output logic [31:0] rdata, output bit mis);
    int k = 0;
    @(negedge clk);
    address = a; write_data = wd; byteenable = ben;
    read_select = rd; write_select = wr; avl_waitrequest = 1'b0;
    #1;
    mis = misalign_err;
    while (busy === 1'b1 && k < 64) begin
      @(negedge clk);
      k++;
      if (wmode == 2)      avl_waitrequest = (k <= 3);
      else if (wmode == 1) avl_waitrequest = ($urandom_range(0, 2) == 0);
      else                 avl_waitrequest = 1'b0;
      #1;
      if (wmode == 2 && k <= 3) checkOutput("busy_wait", busy, 1'b1);
    end
    if (k >= 64) checkOutput("timeout", 1'b1, 1'b0);
    lat = k;
    rdata = read_data;
    @(negedge clk);
    read_select = 1'b0; write_select = 1'b0; avl_waitrequest = 1'b0;
    #3;
  endtask

  task automatic runAccess(input string tag, input bit rd, input bit wr, input logic [31:0] a,
                           input logic [31:0] wd, input logic [3:0] ben, input int wmode, output int lat);
    logic [31:0] exp_rd, got;
    int          exp_nb, nb;
    bit          exp_mis, mis, valid;
    valid = (rd ^ wr) && (ben != 4'h0);
    nb = beat_addr.size();
    modelExpect(a, ben, exp_rd, exp_nb, exp_mis);
    if (!valid) begin
      exp_nb = 0;
      exp_mis = 1'b0;
    end
    applyStimulus(rd, wr, a, wd, ben, wmode, lat, got, mis);
    checkOutput({tag, "_beats"}, beat_addr.size() - nb, exp_nb);
    checkOutput({tag, "_mis"}, mis, exp_mis);
    if (valid && rd) begin
      checkOutput({tag, "_rdata"}, got, exp_rd);
      checkOutput({tag, "_rhold"}, read_data, exp_rd);
      last_read = exp_rd;
    end else begin
      checkOutput({tag, "_rkeep"}, read_data, last_read);
    end
    if (valid && wr) modelWrite(a, wd, ben);
  endtask

  initial begin
    int lat, nb, sel;
    logic [31:0] a;

    rst = 1'b1; read_select = 1'b1; write_select = 1'b0;
    address = 32'h100; byteenable = 4'hF; write_data = 32'h0; avl_waitrequest = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("busy_in_rst", busy, 1'b0);
    rst = 1'b0; read_select = 1'b0;
    #2;
    checkOutput("rst_read",  avl_read, 1'b0);
    checkOutput("rst_write", avl_write, 1'b0);
    checkOutput("rst_addr",  avl_address, 32'h0);
    checkOutput("rst_ben",   avl_byteenable, 4'hF);
    checkOutput("rst_wdata", avl_writedata, 32'h0);
    checkOutput("rst_rdata", read_data, 32'h0);
    checkOutput("rst_busy",  busy, 1'b0);
    checkOutput("rst_mis",   misalign_err, 1'b0);
    @(negedge clk);
    #1;
    checkOutput("no_accept_in_rst", avl_read, 1'b0);

    $display("[TB] aligned read");
    preload(32'h100, 32'hAABBCCDD);
    nb = beat_addr.size();
    runAccess("r031", 1'b1, 1'b0, 32'h100, 32'h0, 4'hF, 0, lat);
    checkOutput("r031_lat", lat, 1);
    checkOutput("r031_rd", read_data, 32'hAABBCCDD);
    checkOutput("r031_addr", beat_addr[nb], 32'h100);
    checkOutput("r031_ben", beat_ben[nb], 4'hF);

    $display("[TB] unaligned read");
    preload(32'h100, 32'h11223344);
    preload(32'h104, 32'h55667788);
    runAccess("r033", 1'b1, 1'b0, 32'h102, 32'h0, 4'hF, 0, lat);
    checkOutput("r033_rd", read_data, SPLIT ? 32'h77881122 : 32'h00001122);
    checkOutput("r033_lat", lat, SPLIT ? 2 : 1);

    $display("[TB] crossing write");
    nb = beat_addr.size();
    runAccess("r032", 1'b0, 1'b1, 32'h103, 32'h00001234, 4'b0011, 0, lat);
    checkOutput("r032_b0_addr", beat_addr[nb], 32'h100);
    checkOutput("r032_b0_ben", beat_ben[nb], 4'b1000);
    checkOutput("r032_b0_data", beat_data[nb], 32'h34000000);
`ifdef AVL_MASTER_SPLIT_EN
    checkOutput("r032_b1_addr", beat_addr[nb+1], 32'h104);
    checkOutput("r032_b1_ben", beat_ben[nb+1], 4'b0001);
    checkOutput("r032_b1_data", beat_data[nb+1], 32'h00000012);
`endif
    runAccess("r034a", 1'b1, 1'b0, 32'h103, 32'h0, 4'b0011, 0, lat);
    checkOutput("r034a_rd", read_data, SPLIT ? 32'h00001234 : 32'h00000034);
    runAccess("r034b", 1'b1, 1'b0, 32'h104, 32'h0, 4'b0001, 0, lat);
    checkOutput("r034b_rd", read_data, SPLIT ? 32'h00000012 : 32'h00000088);

    $display("[TB] stalled beat and mid-beat reset");
    runAccess("r035", 1'b1, 1'b0, 32'h100, 32'h0, 4'hF, 2, lat);
    checkOutput("r035_lat", lat, 4);
    @(negedge clk);
    address = 32'h104; byteenable = 4'hF; read_select = 1'b1; avl_waitrequest = 1'b0;
    @(negedge clk);
    avl_waitrequest = 1'b1; read_select = 1'b0;
    #1;
    checkOutput("mid_read", avl_read, 1'b1);
    checkOutput("mid_busy", busy, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; avl_waitrequest = 1'b0;
    #1;
    checkOutput("post_rst_read", avl_read, 1'b0);
    checkOutput("post_rst_write", avl_write, 1'b0);
    checkOutput("post_rst_busy", busy, 1'b0);
    checkOutput("post_rst_rdata", read_data, 32'h0);
    last_read = 32'h0;

    $display("[TB] address wrap and conflicting strobes");
    preload(32'hFFFFFFFC, 32'h11223344);
    preload(32'h00000000, 32'hAABBCCDD);
    nb = beat_addr.size();
    runAccess("r036", 1'b1, 1'b0, 32'hFFFFFFFE, 32'h0, 4'hF, 0, lat);
    checkOutput("r036_rd", read_data, SPLIT ? 32'hCCDD1122 : 32'h00001122);
`ifdef AVL_MASTER_SPLIT_EN
    checkOutput("r036_b1_addr", beat_addr[nb+1], 32'h0);
`endif
    runAccess("both_sel", 1'b1, 1'b1, 32'h100, 32'h0, 4'hF, 0, lat);
    checkOutput("both_sel_lat", lat, 0);

    $display("[TB] random accesses");
    for (int w = 0; w < 6; w++) preload(32'(32'h200 + 4*w), $urandom);
    preload(32'hFFFFFFF8, $urandom);
    preload(32'h00000004, $urandom);
    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 5);
      a = ($urandom_range(0, 3) == 0) ? 32'(32'hFFFFFFF8 + $urandom_range(0, 7))
                                      : 32'(32'h200 + $urandom_range(0, 15));
      runAccess("rnd", (sel < 3) || (sel == 5), sel >= 3, a, $urandom,
                4'($urandom_range(1, 15)), 1, lat);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
